// File: rtl/ld_st_sequencer_if.sv
// ld_st_sequencer_if
//   Bundles the CPU-side request/response signals and the memory-bus
//   signals of the load/store sequencer.
//   Request : start, is_store, size, sign_ext, addr, wr_data
//   Response: busy, done, error, rd_data
//   Memory  : mem_req, mem_we, mem_addr, mem_be, mem_wdata (to memory),
//             mem_rdata, mem_ack (from memory)
//   modport master : the sequencer (takes requests, masters the memory bus)
//   modport slave  : the environment (CPU requester plus memory responder)
interface ld_st_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int BUS_W  = 16,
  parameter int ADDR_W = 32
);
  logic                  start;
  logic                  is_store;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [ADDR_W-1:0]     addr;
  logic [WORD_W-1:0]     wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [WORD_W-1:0]     rd_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [BUS_W/8-1:0]    mem_be;
  logic [BUS_W-1:0]      mem_wdata;
  logic [BUS_W-1:0]      mem_rdata;
  logic                  mem_ack;

  modport master (
    input  start, is_store, size, sign_ext, addr, wr_data, mem_rdata, mem_ack,
    output busy, done, error, rd_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output start, is_store, size, sign_ext, addr, wr_data, mem_rdata, mem_ack,
    input  busy, done, error, rd_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/ld_st_sequencer.sv
// ld_st_sequencer
//   Splits a byte/half/word load or store into one or more memory-bus beats
//   (little-endian), assembles and extends load data, and reports misaligned
//   or reserved-size requests with error alongside a one-cycle done pulse.
//   Ports:
//     clk  - sole clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - ld_st_sequencer_if.master (request, response and memory signals)
module ld_st_sequencer #(
  parameter int WORD_W = 32,
  parameter int BUS_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ld_st_sequencer_if.master     bus
);
  localparam int BYTES  = BUS_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FIN    = 2'd2
  } state_t;

  state_t              state, state_nx;

  // Request latched in IDLE; the CPU inputs are free to change afterwards.
  logic                req_store;
  logic                req_sext;
  logic                req_err;
  logic [1:0]          req_size;
  logic [ADDR_W-1:0]   req_addr;
  logic [WORD_W-1:0]   req_wdata;
  logic [1:0]          beat;
  logic [WORD_W-1:0]   acc;
  logic [WORD_W-1:0]   rd_q;

  // Decode of the live request, used only when start is taken in IDLE.
  logic [3:0]          in_nbytes;
  logic                in_bad;

  // Decode of the latched request.
  logic [3:0]          nbytes;
  logic                narrow;
  logic [1:0]          last_beat;
  logic [LANE_W-1:0]   lane;
  logic [7:0]          lane_mask;
  logic [BUS_W/8-1:0]  be_cur;
  logic [BUS_W-1:0]    wdata_cur;
  logic [WORD_W-1:0]   raw;
  logic [WORD_W-1:0]   ext_mask;
  logic [WORD_W-1:0]   ext;
  logic                sign_bit;
  logic                in_access;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    in_nbytes = 4'd1 << bus.size;
    in_bad    = (bus.size == 2'd3) || ((bus.addr[2:0] & 3'(in_nbytes - 4'd1)) != 3'd0);

    nbytes    = 4'd1 << req_size;
    narrow    = 32'(nbytes) < BYTES;
    last_beat = narrow ? 2'd0 : 2'(32'(nbytes) / BYTES - 1);
    lane      = (BYTES > 1) ? req_addr[LANE_W-1:0] : '0;
    lane_mask = (8'd1 << nbytes) - 8'd1;

    // Sub-bus accesses live in one beat on the lanes the address selects;
    // wider accesses use whole beats, lowest bytes first.
    be_cur    = narrow ? ((BUS_W/8)'(lane_mask) << lane) : '1;
    wdata_cur = narrow ? (BUS_W'(req_wdata) << {lane, 3'b000})
                       : req_wdata[32'(beat)*BUS_W +: BUS_W];

    // Load data as it stands once the current beat's rdata is merged in.
    raw = acc;
    if (narrow) begin
      raw = WORD_W'(bus.mem_rdata >> {lane, 3'b000});
    end else begin
      raw[32'(beat)*BUS_W +: BUS_W] = bus.mem_rdata;
    end

    // Shifting out the full word width yields zero, so a word-sized mask
    // wraps to all ones without a special case.
    ext_mask = (WORD_W'(1) << (32'(nbytes) * 8)) - WORD_W'(1);
    case (req_size)
      2'd0:    sign_bit = raw[7];
      2'd1:    sign_bit = raw[15];
      default: sign_bit = raw[31];
    endcase
    ext = raw & ext_mask;
    if (req_sext && sign_bit) ext = ext | ~ext_mask;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = in_bad ? FIN : ACCESS;
      ACCESS:  if (bus.mem_ack && (beat == last_beat)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: all datapath registers are reset; the memory-side outputs derive
  // from them and must read zero while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_store <= 1'b0;
      req_sext  <= 1'b0;
      req_err   <= 1'b0;
      req_size  <= 2'd0;
      req_addr  <= '0;
      req_wdata <= '0;
      beat      <= 2'd0;
      acc       <= '0;
      rd_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            req_store <= bus.is_store;
            req_sext  <= bus.sign_ext;
            req_err   <= in_bad;
            req_size  <= bus.size;
            req_addr  <= bus.addr;
            req_wdata <= bus.wr_data;
            beat      <= 2'd0;
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            if (beat == last_beat) begin
              if (!req_store) rd_q <= ext;
            end else begin
              beat <= beat + 2'd1;
              acc  <= raw;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_access     = (state == ACCESS);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FIN);
  assign bus.error     = (state == FIN) && req_err;
  assign bus.rd_data   = rd_q;
  assign bus.mem_req   = in_access;
  assign bus.mem_we    = in_access && req_store;
  assign bus.mem_be    = in_access ? be_cur : '0;
  assign bus.mem_wdata = wdata_cur;
  assign bus.mem_addr  = (req_addr & ~ADDR_W'(BYTES - 1)) + ADDR_W'(32'(beat) * BYTES);
endmodule

// File: tb/tb_ld_st_sequencer.sv
// tb_ld_st_sequencer
//   Directed and randomized load/store requests against a byte-array memory
//   responder. Expected beats and load results come from a byte-by-byte
//   reference model of the little-endian access rules.
module tb_ld_st_sequencer;
  localparam int WORD_W = 32;
  localparam int BUS_W  = 16;
  localparam int ADDR_W = 32;
  localparam int BPB    = BUS_W / 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  be;
    logic        we;
    logic [15:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ld_st_sequencer_if #(.WORD_W(WORD_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) bi ();

  ld_st_sequencer #(.WORD_W(WORD_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi)
  );

  int          checks = 0;
  int          errors = 0;
  bit [7:0]    mem [0:4095];
  beat_t       beats[$];
  int          delays[$];
  beat_t       exp_beats[$];
  bit          exp_err;
  logic [31:0] exp_rd = 32'h0;
  int          ack_delay = 0;
  bit          stable_bad = 0;
  int          done_cnt = 0;
  int          req_cycles = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory responder: each beat waits a chosen number of cycles, then acks
  // with data from mem; store lanes are written into mem.
  initial begin : responder
    bit    pending;
    int    left;
    beat_t cur;
    int    a;
    pending = 0;
    left = 0;
    cur = '0;
    bi.mem_ack = 1'b0;
    bi.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bi.mem_rdata = 16'($urandom);
      if (rst || bi.mem_req !== 1'b1) begin
        bi.mem_ack = 1'b0;
        pending = 0;
      end else begin
        req_cycles++;
        if (!pending) begin
          pending = 1;
          cur.addr = bi.mem_addr;
          cur.be = bi.mem_be;
          cur.we = bi.mem_we;
          cur.wdata = bi.mem_wdata;
          left = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
          delays.push_back(left);
        end else if (bi.mem_addr !== cur.addr || bi.mem_be !== cur.be ||
                     bi.mem_we !== cur.we || bi.mem_wdata !== cur.wdata) begin
          stable_bad = 1;
        end
        if (left == 0) begin
          bi.mem_ack = 1'b1;
          for (int j = 0; j < BPB; j++) begin
            a = (int'(cur.addr[11:0]) + j) & 4095;
            bi.mem_rdata[j*8 +: 8] = mem[a];
            if (cur.we && cur.be[j]) mem[a] = cur.wdata[j*8 +: 8];
          end
          beats.push_back(cur);
          pending = 0;
        end else begin
          bi.mem_ack = 1'b0;
          left--;
        end
      end
    end
  end

  always @(posedge clk) if (bi.done === 1'b1) done_cnt++;

  // Reference model: walks the accessed bytes in ascending address order,
  // grouping them into bus-aligned beats and lanes.
  task automatic model(input logic st, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    int          n;
    beat_t       cur;
    bit          have;
    logic [31:0] v;
    logic [31:0] ba;
    int          lane;
    n = 1 << sz;
    exp_beats = {};
    exp_err = (sz == 2'd3) || (a % n != 0);
    if (exp_err) return;
    have = 0;
    cur = '0;
    for (int i = 0; i < n; i++) begin
      ba = a + i;
      lane = int'(ba % BPB);
      if (have && cur.addr != ba - ba % BPB) begin
        exp_beats.push_back(cur);
        have = 0;
      end
      if (!have) begin
        cur = '0;
        cur.addr = ba - ba % BPB;
        cur.we = st;
        have = 1;
      end
      cur.be[lane] = 1'b1;
      cur.wdata[lane*8 +: 8] = wd[i*8 +: 8];
    end
    exp_beats.push_back(cur);
    if (!st) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[i*8 +: 8] = mem[(a + i) & 32'hFFF];
      if (sx && v[8*n-1]) for (int i = n; i < 4; i++) v[i*8 +: 8] = 8'hFF;
      exp_rd = v;
    end
  endtask

  task automatic do_access(input string tag, input logic st, input logic [1:0] sz,
                           input logic sx, input logic [31:0] a, input logic [31:0] wd,
                           input bit hold_start);
    int lat, exp_lat, d0, r0;
    model(st, sz, sx, a, wd);
    beats = {};
    delays = {};
    stable_bad = 0;
    d0 = done_cnt;
    r0 = req_cycles;
    bi.is_store = st;
    bi.size = sz;
    bi.sign_ext = sx;
    bi.addr = a;
    bi.wr_data = wd;
    bi.start = 1'b1;
    tick();
    if (!hold_start) begin
      bi.start = 1'b0;
      bi.is_store = 1'($urandom);
      bi.size = 2'($urandom);
      bi.sign_ext = 1'($urandom);
      bi.addr = $urandom;
      bi.wr_data = $urandom;
    end
    lat = 1;
    while (bi.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    bi.start = 1'b0;
    check($sformatf("%s.done", tag), bi.done, 1'b1);
    check($sformatf("%s.error", tag), bi.error, exp_err);
    check($sformatf("%s.rd_data", tag), bi.rd_data, exp_rd);
    check($sformatf("%s.nbeats", tag), beats.size(), exp_beats.size());
    if (beats.size() == exp_beats.size()) begin
      for (int k = 0; k < beats.size(); k++) begin
        check($sformatf("%s.addr%0d", tag, k), beats[k].addr, exp_beats[k].addr);
        check($sformatf("%s.be%0d", tag, k), beats[k].be, exp_beats[k].be);
        check($sformatf("%s.we%0d", tag, k), beats[k].we, exp_beats[k].we);
        if (st) begin
          for (int j = 0; j < BPB; j++) begin
            if (exp_beats[k].be[j])
              check($sformatf("%s.wdata%0d.%0d", tag, k, j),
                    beats[k].wdata[j*8 +: 8], exp_beats[k].wdata[j*8 +: 8]);
          end
        end
      end
    end
    exp_lat = 1;
    foreach (delays[i]) exp_lat += delays[i] + 1;
    check($sformatf("%s.latency", tag), lat, exp_lat);
    check($sformatf("%s.stable", tag), stable_bad, 1'b0);
    if (exp_err) check($sformatf("%s.no_req", tag), req_cycles - r0, 0);
    tick();
    check($sformatf("%s.done_low", tag), bi.done, 1'b0);
    check($sformatf("%s.idle", tag), bi.busy, 1'b0);
    check($sformatf("%s.done_cnt", tag), done_cnt - d0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int          d0, n;
    logic        st, sx;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    bi.start = 1'b0;
    bi.is_store = 1'b0;
    bi.size = 2'd0;
    bi.sign_ext = 1'b0;
    bi.addr = '0;
    bi.wr_data = '0;

    // Reset state
    tick();
    tick();
    check("rst.busy", bi.busy, 1'b0);
    check("rst.done", bi.done, 1'b0);
    check("rst.error", bi.error, 1'b0);
    check("rst.mem_req", bi.mem_req, 1'b0);
    check("rst.mem_we", bi.mem_we, 1'b0);
    check("rst.mem_be", bi.mem_be, 2'b00);
    check("rst.rd_data", bi.rd_data, 32'h0);
    check("rst.mem_addr", bi.mem_addr, 32'h0);
    check("rst.mem_wdata", bi.mem_wdata, 16'h0);
    rst = 1'b0;
    tick();

    // Word load, immediate acks
    ack_delay = 0;
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    do_access("w_ld", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0);
    check("w_ld.value", bi.rd_data, 32'h12345678);

    // Signed / unsigned byte load from the upper lane
    mem[12'h100] = 8'hAA; mem[12'h101] = 8'h80;
    do_access("b_ld_s", 1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 1'b0);
    check("b_ld_s.value", bi.rd_data, 32'hFFFFFF80);
    do_access("b_ld_u", 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 1'b0);
    check("b_ld_u.value", bi.rd_data, 32'h00000080);

    // Misaligned half store and reserved size
    do_access("h_st_mis", 1'b1, 2'd1, 1'b0, 32'h203, 32'h1234, 1'b0);
    check("h_st_mis.rd_kept", bi.rd_data, 32'h00000080);
    do_access("rsv", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b0);

    // Word store with three wait cycles per beat
    ack_delay = 3;
    do_access("w_st_slow", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0);
    check("w_st_slow.mem", {mem[12'h43], mem[12'h42], mem[12'h41], mem[12'h40]}, 32'hDEADBEEF);

    // Reset in the second beat of a word load
    ack_delay = 2;
    beats = {};
    d0 = done_cnt;
    bi.is_store = 1'b0; bi.size = 2'd2; bi.sign_ext = 1'b0; bi.addr = 32'h20;
    bi.start = 1'b1;
    tick();
    bi.start = 1'b0;
    n = 0;
    while (!(bi.mem_req === 1'b1 && bi.mem_addr === 32'h22) && n < 20) begin
      tick();
      n++;
    end
    check("rst_mid.second_beat", bi.mem_addr, 32'h22);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.mem_req", bi.mem_req, 1'b0);
    check("rst_mid.busy", bi.busy, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    exp_rd = 32'h0;
    check("rst_mid.rd_data", bi.rd_data, 32'h0);
    check("rst_mid.no_done", done_cnt - d0, 0);
    ack_delay = 0;
    mem[12'h10] = 8'h9C;
    do_access("after_rst", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0);
    check("after_rst.value", bi.rd_data, 32'hFFFFFF9C);

    // start held high for the whole access
    ack_delay = 1;
    do_access("busy_start", 1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 1'b1);
    n = beats.size();
    d0 = done_cnt;
    repeat (4) tick();
    check("busy_start.no_extra_beat", beats.size(), n);
    check("busy_start.no_extra_done", done_cnt - d0, 0);

    // Randomized accesses in a small window so stores and loads overlap
    ack_delay = -1;
    for (int t = 0; t < 60; t++) begin
      st = 1'($urandom);
      sz = 2'($urandom);
      sx = 1'($urandom);
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      do_access($sformatf("rnd%0d", t), st, sz, sx, a, $urandom, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ld_st_sequencer.md
LD_ST_SEQUENCER -- requirements
Module: ld_st_sequencer

Interface
REQ-001 Parameter WORD_W, default 32: CPU word width, a multiple of BUS_W and at least 32.
REQ-002 Parameter BUS_W, default 16: memory bus data width, one of 8/16/32.
REQ-003 Parameter ADDR_W, default 32: byte-address width.
REQ-004 The design SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  request a load/store; sampled only in IDLE.
REQ-008 is_store  in  1  1 = store, 0 = load.
REQ-009 size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-010 sign_ext  in  1  loads: sign-extend (1) or zero-extend (0) to WORD_W.
REQ-011 addr  in  ADDR_W  byte address.
REQ-012 wr_data  in  WORD_W  store data, right-aligned.
REQ-013 busy  out  1  high in ACCESS and FIN.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 error  out  1  valid with done; misaligned address or size=3.
REQ-016 rd_data  out  WORD_W  load result, held until the next completed load.
REQ-017 mem_req / mem_we  out  1 / 1  bus request and write enable.
REQ-018 mem_addr  out  ADDR_W  byte address of the current beat, aligned down to BUS_W/8.
REQ-019 mem_be  out  BUS_W/8  byte-lane enables; mem_wdata out BUS_W; mem_rdata in BUS_W; mem_ack in 1.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and FIN, each with an explicit encoding.
REQ-021 IDLE with start=1 SHALL latch all request inputs; a misaligned request (addr not a multiple of 2^size) or size=3 SHALL go to FIN with error=1, raise no mem_req and leave rd_data unchanged; any other request SHALL go to ACCESS.
REQ-022 Byte count N = 2^size; beat count B = max(1, N/(BUS_W/8)); the beat index SHALL count 0 to B-1.
REQ-023 In ACCESS, mem_req=1, and mem_we, mem_addr, mem_be and mem_wdata SHALL remain stable until the cycle in which mem_ack=1.
REQ-024 On an ack that is not the last beat, the sequencer SHALL advance to beat k+1 and step mem_addr by BUS_W/8, with mem_req still high in the next cycle (back-to-back beats).
REQ-025 On the ack of the last beat, the FSM SHALL go to FIN; FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-026 The data format SHALL be little-endian: beat k carries bytes k*BUS_W/8 and upward of the word.
REQ-027 For an access narrower than the bus, the sequencer SHALL select lanes starting at addr mod (BUS_W/8), set mem_be on those lanes only, and shift store data onto them.
REQ-028 For full-bus beats, mem_be SHALL be all ones.
REQ-029 A load SHALL assemble the beats, then extend from bit 8N-1 per sign_ext, and update rd_data in the FIN cycle.
REQ-030 start while busy=1 SHALL be ignored; mem_ack outside ACCESS SHALL be ignored.
REQ-031 Minimum latency SHALL be B+1 cycles from start to done, with ack in the same cycle as each request.

Reset
REQ-032 When rst is asserted, the block SHALL enter IDLE immediately and asynchronously, with busy, done, error, mem_req, mem_we and mem_be at 0, and rd_data, mem_addr and mem_wdata at 0.
REQ-033 rst during ACCESS SHALL drop mem_req in the same cycle, produce no done, and discard the partial beat data.
REQ-034 The first start after rst deasserts SHALL be accepted normally.

Verification (WORD_W=32, BUS_W=16)
REQ-035 Word load at 0x100, immediate acks, rdata 0x5678 then 0x1234 -> mem_addr 0x100 then 0x102, mem_be 2'b11, rd_data 0x12345678, done 3 cycles after start.
REQ-036 Signed byte load at 0x101, rdata 0x80AA -> mem_addr 0x100, mem_be 2'b10, rd_data 0xFFFFFF80; the same access with sign_ext=0 -> rd_data 0x00000080.
REQ-037 Half store at 0x203 -> done and error in the same cycle, mem_req never high, rd_data unchanged.
REQ-038 Word store of 0xDEADBEEF at 0x40, ack delayed 3 cycles per beat -> mem_wdata 0xBEEF at 0x40 held stable for 4 cycles, then 0xDEAD at 0x42; done follows the second ack by 1 cycle.
REQ-039 rst asserted during the second beat of a word load -> mem_req=0 asynchronously, no done; a following byte load at 0x10 completes normally.
REQ-040 start pulsed while busy -> no second access; beat count and done pulse count stay exactly one per accepted request.
